// File: rtl/wbram_pkg.sv
// wbram_pkg: shared read/write pointer types and helpers for the double-buffered weight BRAM.
package wbram_pkg;
  localparam int PTR_W = 2;
  typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, RELEASE} rd_state_t;
  function automatic logic ptr_empty(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
    return wr == rd;
  endfunction
  // Full when the writer is exactly one lap ahead: same half, opposite wrap bit.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
    return (wr ^ rd) == 2'b10;
  endfunction
endpackage

// File: rtl/wbram_rd_scheduler_if.sv
// wbram_rd_scheduler_if: pointer, config, bank-read and weight-stream signals of the read scheduler.
interface wbram_rd_scheduler_if #(
  parameter int WBRAM_WIDTH = 128,
  parameter int NUM_BANKS = 16,
  parameter int WBRAM_DEPTH = 112,
  parameter int MAX_ACCUM = 225,
  parameter int MAX_GROUPS = 8
);
  import wbram_pkg::*;
  localparam int AW = $clog2(WBRAM_DEPTH);
  localparam int DW = NUM_BANKS * WBRAM_WIDTH;
  localparam int CW = $clog2(MAX_ACCUM + 1);
  localparam int GW = $clog2(MAX_GROUPS + 1);
  logic [PTR_W-1:0] wr_ptr_data;
  logic wr_ptr_valid, wr_ptr_ready;
  logic [PTR_W-1:0] rd_ptr_data;
  logic rd_ptr_valid, rd_ptr_ready;
  logic [CW-1:0] cfg_accum_total;
  logic [GW-1:0] cfg_num_groups;
  logic cfg_valid, cfg_ready;
  logic [AW-1:0] addrB;
  logic enB, ping_pong_rd;
  logic [DW-1:0] doB, w_data;
  logic w_valid, w_ready, w_last_group, w_last;
  modport master (
    input wr_ptr_data, wr_ptr_valid, output wr_ptr_ready,
    output rd_ptr_data, rd_ptr_valid, input rd_ptr_ready,
    input cfg_accum_total, cfg_num_groups, cfg_valid, output cfg_ready,
    output addrB, enB, ping_pong_rd, input doB,
    output w_data, w_valid, w_last_group, w_last, input w_ready
  );
  modport slave (
    output wr_ptr_data, wr_ptr_valid, input wr_ptr_ready,
    input rd_ptr_data, rd_ptr_valid, output rd_ptr_ready,
    output cfg_accum_total, cfg_num_groups, cfg_valid, input cfg_ready,
    input addrB, enB, ping_pong_rd, output doB,
    input w_data, w_valid, w_last_group, w_last, output w_ready
  );
endinterface

// File: rtl/wbram_rd_fifo.sv
// wbram_rd_fifo: 2-entry output FIFO carrying the weight word and its last/last_group tags.
module wbram_rd_fifo #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic valid,
  output logic [1:0] count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign dout = mem[rp];
  assign valid = count != 2'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/wbram_rd_scheduler.sv
// wbram_rd_scheduler: waits for a filled weight buffer, bursts it out group by group, then releases it.
module wbram_rd_scheduler
  import wbram_pkg::*;
(
  input logic clk,
  input logic rst_n,
  wbram_rd_scheduler_if.master bus
);
  localparam int AW = $bits(bus.addrB);
  localparam int DW = $bits(bus.doB);
  localparam int CW = $bits(bus.cfg_accum_total);
  localparam int GW = $bits(bus.cfg_num_groups);
  rd_state_t state;
  logic [CW-1:0] acc_total, word;
  logic [GW-1:0] num_groups, group;
  logic [AW-1:0] base;
  logic [PTR_W-1:0] rd_ptr_local, wr_ptr_local;
  logic en_d, lg_d, l_d, pop, last_word, last_group, zero_cfg, empty, go_rel;
  logic [1:0] count, occ;
  logic [DW+1:0] head;
  assign last_word = word == acc_total - CW'(1);
  assign last_group = group == num_groups - GW'(1);
  assign zero_cfg = acc_total == '0 || num_groups == '0;
  assign empty = ptr_empty(wr_ptr_local, rd_ptr_local);
  assign pop = bus.w_valid & bus.w_ready;
  // Occupancy after this cycle's pop, counting the word already on doB; a new issue lands two edges later.
  assign occ = count + 2'(en_d) - 2'(pop);
  assign bus.enB = state == READ && occ < 2'd2;
  assign bus.addrB = base + AW'(word);
  assign bus.ping_pong_rd = rd_ptr_local[0];
  assign bus.wr_ptr_ready = 1'b1;
  assign go_rel = (state == WAIT && !empty && zero_cfg) || (state == DRAIN && count == 2'd0 && !en_d);
  assign bus.w_data = head[DW+1:2];
  assign bus.w_last_group = head[1];
  assign bus.w_last = head[0];
  wbram_rd_fifo #(.W(DW + 2)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(en_d),
    .din({bus.doB, lg_d, l_d}),
    .pop(pop),
    .dout(head),
    .valid(bus.w_valid),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.cfg_ready <= 1'b0;
      bus.rd_ptr_valid <= 1'b0;
      bus.rd_ptr_data <= '0;
      rd_ptr_local <= '0;
      wr_ptr_local <= '0;
      en_d <= 1'b0;
      lg_d <= 1'b0;
      l_d <= 1'b0;
      acc_total <= '0;
      num_groups <= '0;
      word <= '0;
      group <= '0;
      base <= '0;
    end else begin
      if (bus.wr_ptr_valid) wr_ptr_local <= bus.wr_ptr_data;
      en_d <= bus.enB;
      lg_d <= last_word;
      l_d <= last_word && last_group;
      case (state)
        IDLE: begin
          if (bus.cfg_valid && bus.cfg_ready) begin
            acc_total <= bus.cfg_accum_total;
            num_groups <= bus.cfg_num_groups;
            word <= '0;
            group <= '0;
            base <= '0;
            bus.cfg_ready <= 1'b0;
            state <= WAIT;
          end else bus.cfg_ready <= 1'b1;
        end
        WAIT: if (!empty && !zero_cfg) state <= READ;
        READ: begin
          if (bus.enB) begin
            if (last_word) begin
              word <= '0;
              group <= group + GW'(1);
              base <= base + AW'(acc_total);
              if (last_group) state <= DRAIN;
            end else word <= word + CW'(1);
          end
        end
        RELEASE: begin
          if (bus.rd_ptr_ready) begin
            bus.rd_ptr_valid <= 1'b0;
            bus.cfg_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: ;
      endcase
      if (go_rel) begin
        rd_ptr_local <= rd_ptr_local + PTR_W'(1);
        bus.rd_ptr_data <= rd_ptr_local + PTR_W'(1);
        bus.rd_ptr_valid <= 1'b1;
        state <= RELEASE;
      end
    end
  end
endmodule

// File: doc/wbram_rd_scheduler.md
Name: wbram_rd_scheduler

Overview:
Read-side sequencer for the double-buffered weight BRAM (NUM_BANKS banks, ping/pong halves) filled by the write controller. It tracks the write pointer, waits for a filled buffer, then issues per-layer read bursts to all banks in parallel. The bursts are ordered by out-channel group, then by accum word. Read data is forwarded to the compute array through a valid/ready stream. When a buffer is fully consumed, the block releases it by returning an updated read pointer to the write controller.

Parameters:
WBRAM_WIDTH, 128, width of one bank read word
NUM_BANKS, 16, number of parallel weight banks
WBRAM_DEPTH, 112, words per bank per buffer half
MAX_ACCUM, 225, maximum accum_total (in_channels*kernel_size words per out channel)
MAX_GROUPS, 8, maximum out-channel groups per layer (MAX_OUT_CHANNEL/NUM_BANKS)
AW, $clog2(WBRAM_DEPTH), read address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
wr_ptr_data  in  2  write pointer; bit0 = buffer index, bit1 = wrap
wr_ptr_valid  in  1  write pointer valid
wr_ptr_ready  out  1  write pointer ready
rd_ptr_data  out  2  read pointer returned to the writer
rd_ptr_valid  out  1  read pointer valid
rd_ptr_ready  in  1  writer accepts the read pointer
cfg_accum_total  in  $clog2(MAX_ACCUM+1)  words per out channel for the layer
cfg_num_groups  in  $clog2(MAX_GROUPS+1)  out-channel groups for the layer
cfg_valid  in  1  layer config valid
cfg_ready  out  1  layer config accepted
addrB  out  AW  bank read address (broadcast to all banks)
enB  out  1  read enable (broadcast to all banks)
ping_pong_rd  out  1  buffer half being read (= rd_ptr_local[0])
doB  in  NUM_BANKS*WBRAM_WIDTH  concatenated bank outputs; valid 1 cycle after enB
w_data  out  NUM_BANKS*WBRAM_WIDTH  weight word to compute
w_valid  out  1  weight word valid
w_ready  in  1  compute accepts the word
w_last_group  out  1  last word of the current out-channel group
w_last  out  1  last word of the layer

Behaviour:
- Reset values: wr_ptr_ready=1, rd_ptr_valid=0, rd_ptr_data=0, cfg_ready=0, addrB=0, enB=0, w_valid=0, w_last=0, w_last_group=0. Internal rd_ptr_local=0, wr_ptr_local=0, state IDLE, output FIFO empty.
- Reset applied mid-burst aborts the burst with no drain.
- wr_ptr_ready is held at 1. On each wr_ptr_valid cycle, wr_ptr_local <= wr_ptr_data.
- empty = (wr_ptr_local == rd_ptr_local).
- States:
  - IDLE: cfg_ready=1. A cfg handshake latches accum_total and num_groups, then goes to WAIT.
  - Zero-sized config: accum_total=0 or num_groups=0 skips READ and goes straight to RELEASE. No words are emitted.
  - WAIT: go to READ when !empty. The empty test uses the registered wr_ptr_local, so a pointer update cannot be consumed in the same cycle.
  - READ: issue reads with addrB = group*accum_total + word. word counts 0..accum_total-1, then wraps to 0 and group increments. The last issue (group=num_groups-1, word=accum_total-1) goes to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to RELEASE.
  - RELEASE: rd_ptr_local increments mod 4. Drive rd_ptr_valid=1 with rd_ptr_data = the new value, and hold until rd_ptr_ready. Then go to IDLE.
- Address arithmetic: addrB is computed with a running base register (base += accum_total at each group wrap), not a multiplier. The product must stay ≤ WBRAM_DEPTH; an oversized config is a caller error and behaviour is undefined.
- Flow control:
  - Output path is a 2-entry FIFO.
  - enB=1 only when state=READ and (fifo_count + inflight) < 2.
  - doB is captured into the FIFO exactly 1 cycle after enB.
  - The FIFO head drives w_data and w_valid. It pops on w_valid & w_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - With w_ready held at 1, throughput is 1 word/cycle.
- Sideband: w_last_group and w_last are tagged at issue time, travel with the data through the FIFO, and are valid only when w_valid=1.
- Latency: first enB 1 cycle after entering READ; first w_valid 2 cycles after that enB.
- Full double buffer: if the writer fills both halves (wr_ptr ahead by 2), the scheduler processes them in order, one config per buffer.

Decomposition:
- Package wbram_pkg holds:
  - the rd_state_t enum {IDLE, WAIT, READ, DRAIN, RELEASE};
  - the pointer width constant PTR_W=2;
  - the empty/full helper functions, shared with the write controller.
- One sub-module, wbram_rd_fifo: a 2-entry FIFO of {data, last_group, last} with count output.

Test Plan:
- Pointer gating: reset, cfg accum_total=3, num_groups=2, wr_ptr stays 0 -> no enB. Then wr_ptr=1 -> addrB sequence 0,1,2,3,4,5 and 6 words out. w_last_group on words 3 and 6, w_last on word 6. Then rd_ptr_data=1 with rd_ptr_valid.
- Backpressure: same config, w_ready toggling 1,0,0,1 -> never more than 2 words buffered. No word lost or duplicated; order matches addrB 0..5.
- Double buffer and wrap: four back-to-back layers, wr_ptr 1,2,3,0 -> ping_pong_rd 0,1,0,1. rd_ptr returned 1,2,3,0.
- Release stall: rd_ptr_ready held 0 for 5 cycles -> rd_ptr_valid and rd_ptr_data stable, cfg_ready=0 until the handshake completes.
- Zero config: accum_total=0 -> no enB, no w_valid; rd_ptr still advances by 1.
- Mid-burst reset: rst_n=0 at word 2 -> next cycle enB=0, w_valid=0, rd_ptr_local=0, state IDLE.
